// File: rtl/bp_pkg.sv
// Shared defaults and types for the gshare predictor and its branch target buffer.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package bp_pkg;

    localparam int DEF_HIST_BITS  = 4;
    localparam int DEF_INDEX_BITS = 6;
    localparam int DEF_CTR_BITS   = 2;

    // Widest possible tag (PC[31:2] with a 0-bit index); narrower tags sit right-justified.
    localparam int BTB_TAG_MAX = 30;

    typedef struct packed {
        logic                   valid;
        logic [BTB_TAG_MAX-1:0] tag;
        logic [31:0]            target;
    } btb_entry_t;

    // Weakly not-taken value: one below the taken threshold.
    function automatic logic [3:0] ctr_reset_val(input int ctr_bits);
        return 4'((1 << (ctr_bits - 1)) - 1);
    endfunction

endpackage

// File: rtl/branch_target_buffer.sv
// Direct-mapped branch target buffer indexed by PC[INDEX_BITS+1:2], tagged by the upper PC bits.
// Latency: one cycle from rd_en to hit/target; writes visible to reads on the following cycle.
// Backpressure: none; one read and one write accepted every cycle.
module branch_target_buffer
    import bp_pkg::*;
#(
    parameter int INDEX_BITS = DEF_INDEX_BITS
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rd_en,
    input  logic [31:0] rd_pc,
    input  logic        wr_en,
    input  logic [31:0] wr_pc,
    input  logic [31:0] wr_target,
    output logic        hit,
    output logic [31:0] target
);

    localparam int ENTRIES = 1 << INDEX_BITS;

    btb_entry_t             entries [ENTRIES];
    logic [INDEX_BITS-1:0]  rd_idx;
    logic [INDEX_BITS-1:0]  wr_idx;
    logic [BTB_TAG_MAX-1:0] rd_tag;
    logic [BTB_TAG_MAX-1:0] wr_tag;
    btb_entry_t             rd_entry;
    logic                   rd_match;
    logic                   unused_low;

    assign rd_idx     = rd_pc[INDEX_BITS+1:2];
    assign wr_idx     = wr_pc[INDEX_BITS+1:2];
    assign rd_tag     = BTB_TAG_MAX'(rd_pc[31:INDEX_BITS+2]);
    assign wr_tag     = BTB_TAG_MAX'(wr_pc[31:INDEX_BITS+2]);
    assign rd_entry   = entries[rd_idx];
    assign rd_match   = rd_entry.valid && (rd_entry.tag == rd_tag);
    assign unused_low = ^{rd_pc[1:0], wr_pc[1:0]};

    // Storage: only valid bits are reset; tag and target are don't-care until written.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                entries[i].valid <= 1'b0;
            end
        end else if (wr_en) begin
            entries[wr_idx] <= '{valid: 1'b1, tag: wr_tag, target: wr_target};
        end
    end

    // Registered read port; outputs hold when no read is requested, target is zero on a miss.
    always_ff @(posedge clk) begin
        if (rst) begin
            hit    <= 1'b0;
            target <= '0;
        end else if (rd_en) begin
            hit    <= rd_match;
            target <= rd_match ? rd_entry.target : 32'h0;
        end
    end

endmodule

// File: rtl/gshare_branch_predictor.sv
// Gshare direction predictor (PC xor global history into a saturating-counter table); optional BTB under BP_BTB_EN.
// Latency: one cycle from lookup request to Prediction/PredValid; same-cycle updates bypass into the lookup.
// Backpressure: none; a lookup and an update are accepted every cycle without stalling.
module gshare_branch_predictor
    import bp_pkg::*;
#(
    parameter int HIST_BITS  = DEF_HIST_BITS,
    parameter int INDEX_BITS = DEF_INDEX_BITS,
    parameter int CTR_BITS   = DEF_CTR_BITS
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  BranchInstructExists_ID,
    input  logic [31:0]           PCNow_ID,
    input  logic                  BranchInstructExists_EX,
    input  logic                  BranchDecision_EX,
    input  logic [INDEX_BITS-1:0] PredIndex_EX,
    input  logic [31:0]           PCNow_EX,
    input  logic [31:0]           BranchTarget_EX,
    output logic                  Prediction,
    output logic                  PredValid,
    output logic [INDEX_BITS-1:0] PredIndex_ID,
    output logic [31:0]           PredTarget,
    output logic                  PredTargetValid
);

    localparam int                  ENTRIES  = 1 << INDEX_BITS;
    localparam logic [CTR_BITS-1:0] CTR_MAX  = '1;
    localparam logic [CTR_BITS-1:0] CTR_INIT = CTR_BITS'(ctr_reset_val(CTR_BITS));

    logic [CTR_BITS-1:0]   pht [ENTRIES];
    logic [HIST_BITS-1:0]  hist;
    logic [INDEX_BITS-1:0] lk_idx;
    logic [CTR_BITS-1:0]   upd_cur;
    logic [CTR_BITS-1:0]   upd_next;
    logic [CTR_BITS-1:0]   lk_ctr;

    // Lookup always uses the history as it stands before any same-cycle shift.
    assign lk_idx  = PCNow_ID[INDEX_BITS+1:2] ^ INDEX_BITS'(hist);
    assign upd_cur = pht[PredIndex_EX];

    // Saturating increment on taken, decrement on not-taken.
    always_comb begin
        upd_next = upd_cur;
        if (BranchDecision_EX) begin
            if (upd_cur != CTR_MAX) upd_next = upd_cur + 1'b1;
        end else begin
            if (upd_cur != '0) upd_next = upd_cur - 1'b1;
        end
    end

    // Write-through: a lookup hitting the entry being updated sees the new count.
    assign lk_ctr = (BranchInstructExists_EX && (PredIndex_EX == lk_idx)) ? upd_next : pht[lk_idx];

    // Pattern table and global history update on each resolved branch.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                pht[i] <= CTR_INIT;
            end
            hist <= '0;
        end else if (BranchInstructExists_EX) begin
            pht[PredIndex_EX] <= upd_next;
            hist              <= HIST_BITS'({hist, BranchDecision_EX});
        end
    end

    // Registered lookup result; Prediction and PredIndex_ID hold between requests.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            Prediction   <= 1'b0;
            PredValid    <= 1'b0;
            PredIndex_ID <= '0;
        end else begin
            PredValid <= BranchInstructExists_ID;
            if (BranchInstructExists_ID) begin
                Prediction   <= lk_ctr[CTR_BITS-1];
                PredIndex_ID <= lk_idx;
            end
        end
    end

`ifdef BP_BTB_EN
    branch_target_buffer #(
        .INDEX_BITS (INDEX_BITS)
    ) u_btb (
        .clk       (Clock),
        .rst       (Reset),
        .rd_en     (BranchInstructExists_ID),
        .rd_pc     (PCNow_ID),
        .wr_en     (BranchInstructExists_EX && BranchDecision_EX),
        .wr_pc     (PCNow_EX),
        .wr_target (BranchTarget_EX),
        .hit       (PredTargetValid),
        .target    (PredTarget)
    );
`else
    logic unused_btb_pins;

    assign PredTarget      = '0;
    assign PredTargetValid = 1'b0;
    assign unused_btb_pins = ^{PCNow_ID, PCNow_EX, BranchTarget_EX};
`endif

endmodule

// File: tb/tb_gshare_branch_predictor.sv
// Directed bench for the gshare predictor; BTB expectations follow BP_BTB_EN.
// Latency: checks sample one cycle after each request, #1 past the rising edge.
// Backpressure: none exercised; requests are issued every cycle where needed.
module tb_gshare_branch_predictor;

`ifdef BP_BTB_EN
    localparam bit BTB = 1'b1;
`else
    localparam bit BTB = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        id_v;
    logic [31:0] id_pc;
    logic        ex_v;
    logic        ex_d;
    logic [5:0]  ex_idx;
    logic [31:0] ex_pc;
    logic [31:0] ex_tgt;
    logic        pred;
    logic        pred_valid;
    logic [5:0]  pred_idx;
    logic [31:0] pred_tgt;
    logic        pred_tgt_valid;

    int tests = 0;
    int fails = 0;

    gshare_branch_predictor dut (
        .Clock                   (clk),
        .Reset                   (rst),
        .BranchInstructExists_ID (id_v),
        .PCNow_ID                (id_pc),
        .BranchInstructExists_EX (ex_v),
        .BranchDecision_EX       (ex_d),
        .PredIndex_EX            (ex_idx),
        .PCNow_EX                (ex_pc),
        .BranchTarget_EX         (ex_tgt),
        .Prediction              (pred),
        .PredValid               (pred_valid),
        .PredIndex_ID            (pred_idx),
        .PredTarget              (pred_tgt),
        .PredTargetValid         (pred_tgt_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_id(input logic v, input logic [31:0] pc);
        id_v  = v;
        id_pc = pc;
    endtask

    task automatic set_ex(input logic v, input logic d, input logic [5:0] idx,
                          input logic [31:0] pc, input logic [31:0] tgt);
        ex_v   = v;
        ex_d   = d;
        ex_idx = idx;
        ex_pc  = pc;
        ex_tgt = tgt;
    endtask

    task automatic idle();
        set_id(1'b0, 32'h0);
        set_ex(1'b0, 1'b0, 6'h0, 32'h0, 32'h0);
    endtask

    task automatic resolve(input logic d, input logic [5:0] idx, input int n);
        for (int i = 0; i < n; i++) begin
            set_ex(1'b1, d, idx, 32'h0, 32'h0);
            tick();
        end
        idle();
    endtask

    initial begin
        // Reset with a lookup and an update presented; both must be discarded.
        rst = 1'b1;
        set_id(1'b1, 32'h40);
        set_ex(1'b1, 1'b1, 6'h10, 32'h40, 32'h80);
        tick();
        tick();
        check("rst_valid", 32'(pred_valid), 32'h0);
        check("rst_pred", 32'(pred), 32'h0);
        check("rst_idx", 32'(pred_idx), 32'h0);
        check("rst_tgt", pred_tgt, 32'h0);
        check("rst_tgt_valid", 32'(pred_tgt_valid), 32'h0);

        // First lookup: PC 0x40 -> index 0x10, counter weakly not-taken.
        rst = 1'b0;
        idle();
        set_id(1'b1, 32'h40);
        tick();
        check("first_valid", 32'(pred_valid), 32'h1);
        check("first_pred", 32'(pred), 32'h0);
        check("first_idx", 32'(pred_idx), 32'h10);
        idle();
        tick();
        check("hold_valid", 32'(pred_valid), 32'h0);
        check("hold_idx", 32'(pred_idx), 32'h10);
        check("hold_pred", 32'(pred), 32'h0);

        // Two taken at 0x10 (ctr 3), four not-taken at 0x20 (ctr 0) -> history back to 0.
        resolve(1'b1, 6'h10, 2);
        resolve(1'b0, 6'h20, 4);
        set_id(1'b1, 32'h40);
        tick();
        check("taken_pred", 32'(pred), 32'h1);
        check("taken_idx", 32'(pred_idx), 32'h10);
        set_id(1'b1, 32'h80);
        tick();
        check("sat0_pred", 32'(pred), 32'h0);
        check("sat0_idx", 32'(pred_idx), 32'h20);
        check("b2b_valid", 32'(pred_valid), 32'h1);
        idle();

        // Six more taken must hold at 3: one decrement keeps MSB set, a second clears it.
        resolve(1'b1, 6'h10, 6);
        resolve(1'b0, 6'h10, 1);
        resolve(1'b0, 6'h20, 3);
        set_id(1'b1, 32'h40);
        tick();
        check("sat3_pred_after_dec1", 32'(pred), 32'h1);
        idle();
        resolve(1'b0, 6'h10, 1);
        set_id(1'b1, 32'h40);
        tick();
        check("sat3_pred_after_dec2", 32'(pred), 32'h0);
        check("sat3_idx", 32'(pred_idx), 32'h10);
        idle();

        // T, T, N, T -> history 1101; PC 0 looks up index 0x0D.
        resolve(1'b1, 6'h30, 1);
        resolve(1'b1, 6'h30, 1);
        resolve(1'b0, 6'h30, 1);
        resolve(1'b1, 6'h30, 1);
        set_id(1'b1, 32'h0);
        tick();
        check("hist_idx", 32'(pred_idx), 32'h0D);
        check("hist_pred", 32'(pred), 32'h0);

        // Same-cycle taken update at 0x0D (ctr 1 -> 2) and lookup: bypass, pre-shift history.
        set_id(1'b1, 32'h0);
        set_ex(1'b1, 1'b1, 6'h0D, 32'h0, 32'h0);
        tick();
        check("bypass_pred", 32'(pred), 32'h1);
        check("bypass_idx", 32'(pred_idx), 32'h0D);
        idle();
        set_id(1'b1, 32'h0);
        tick();
        check("postshift_idx", 32'(pred_idx), 32'h0B);
        check("postshift_pred", 32'(pred), 32'h0);
        set_id(1'b1, 32'h4);
        tick();
        check("b2b_idx", 32'(pred_idx), 32'h0A);
        check("b2b_valid2", 32'(pred_valid), 32'h1);
        idle();

        // Taken at PC 0x100 -> 0x200 (history 0111); lookup hit, tag miss, not-taken must not write.
        set_ex(1'b1, 1'b1, 6'h3F, 32'h100, 32'h200);
        tick();
        idle();
        set_id(1'b1, 32'h100);
        tick();
        check("btb_hit_valid", 32'(pred_tgt_valid), 32'(BTB));
        check("btb_hit_tgt", pred_tgt, BTB ? 32'h200 : 32'h0);
        check("btb_hit_idx", 32'(pred_idx), 32'h07);
        set_id(1'b1, 32'h1100);
        tick();
        check("btb_tagmiss_valid", 32'(pred_tgt_valid), 32'h0);
        check("btb_tagmiss_tgt", pred_tgt, 32'h0);
        idle();
        set_ex(1'b1, 1'b0, 6'h3F, 32'h100, 32'h300);
        tick();
        idle();
        set_id(1'b1, 32'h100);
        tick();
        check("btb_nt_nowrite_tgt", pred_tgt, BTB ? 32'h200 : 32'h0);
        check("btb_nt_nowrite_valid", 32'(pred_tgt_valid), 32'(BTB));

        // Mid-stream reset with a lookup and an update pending (history was 1110).
        rst = 1'b1;
        set_id(1'b1, 32'h0);
        set_ex(1'b1, 1'b1, 6'h10, 32'h100, 32'h500);
        tick();
        check("mid_rst_valid", 32'(pred_valid), 32'h0);
        check("mid_rst_idx", 32'(pred_idx), 32'h0);
        check("mid_rst_tgt_valid", 32'(pred_tgt_valid), 32'h0);
        rst = 1'b0;
        idle();
        set_id(1'b1, 32'hC0);
        tick();
        check("mid_rst_hist_idx", 32'(pred_idx), 32'h30);
        check("mid_rst_ctr_pred", 32'(pred), 32'h0);
        set_id(1'b1, 32'h100);
        tick();
        check("mid_rst_btb_valid", 32'(pred_tgt_valid), 32'h0);
        check("mid_rst_btb_tgt", pred_tgt, 32'h0);
        check("mid_rst_idx2", 32'(pred_idx), 32'h00);
        idle();
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/gshare_branch_predictor.md
GSHARE_BRANCH_PREDICTOR -- requirements
Module: gshare_branch_predictor

Interface
REQ-001 Parameter HIST_BITS, default 4: global history length; legal range 1..INDEX_BITS.
REQ-002 Parameter INDEX_BITS, default 6: pattern table holds 2^INDEX_BITS counters.
REQ-003 Parameter CTR_BITS, default 2: saturating counter width; legal range 2..4.
REQ-004 Clock  in  1: single clock; all state changes on its rising edge.
REQ-005 Reset  in  1: synchronous, active-high reset.
REQ-006 BranchInstructExists_ID  in  1: lookup request for a branch in ID.
REQ-007 PCNow_ID  in  32: PC of the ID branch.
REQ-008 BranchInstructExists_EX  in  1: resolution of a branch in EX.
REQ-009 BranchDecision_EX  in  1: resolved direction, 1 = taken.
REQ-010 PredIndex_EX  in  INDEX_BITS: table index returned with the resolving branch.
REQ-011 PCNow_EX  in  32: PC of the resolving branch.
REQ-012 BranchTarget_EX  in  32: resolved target address.
REQ-013 Prediction  out  1: predicted direction, registered.
REQ-014 PredValid  out  1: Prediction and PredIndex_ID are valid this cycle.
REQ-015 PredIndex_ID  out  INDEX_BITS: index used for the lookup; the pipeline carries it to PredIndex_EX.
REQ-016 PredTarget  out  32: predicted target address.
REQ-017 PredTargetValid  out  1: PredTarget is a BTB hit.

Function
REQ-018 Lookup index SHALL be PCNow_ID[INDEX_BITS+1:2] XOR the history zero-extended to INDEX_BITS.
REQ-019 Lookup latency SHALL be one cycle: a request in cycle t drives PredValid=1 in t+1 with Prediction = counter MSB; with no request, PredValid=0 and the other outputs hold.
REQ-020 On BranchInstructExists_EX, the counter at PredIndex_EX SHALL increment when taken and decrement when not taken, saturating at 2^CTR_BITS-1 and at 0.
REQ-021 On BranchInstructExists_EX, the history SHALL shift left by one with BranchDecision_EX entering at bit 0; the oldest bit is discarded.
REQ-022 When a lookup and an update hit the same index in the same cycle, the lookup SHALL use the post-update counter value (write-through bypass).
REQ-023 When a lookup and an update occur in the same cycle, the lookup index SHALL use the pre-shift history.
REQ-024 Update and lookup SHALL be independent; back-to-back requests every cycle SHALL be sustained with no stall.

Reset
REQ-025 While Reset=1: all counters SHALL be set to 2^(CTR_BITS-1)-1 (weakly not-taken), the history to 0, and Prediction, PredValid, PredIndex_ID, PredTarget and PredTargetValid to 0.
REQ-026 Lookups and updates presented in a Reset cycle SHALL be discarded, and PredValid SHALL be 0 in the following cycle.

Configuration
REQ-027 Macro BP_BTB_EN defined: a direct-mapped BTB SHALL be present with 2^INDEX_BITS entries, each holding a valid bit, tag PC[31:INDEX_BITS+2] and a 32-bit target.
REQ-028 BTB lookup SHALL be indexed by PCNow_ID[INDEX_BITS+1:2], with the same latency as Prediction; PredTargetValid=1 only on valid and tag match.
REQ-029 BTB write SHALL occur only when BranchInstructExists_EX and BranchDecision_EX are both 1, indexed by PCNow_EX; valid bits SHALL clear on Reset.
REQ-030 Macro BP_BTB_EN undefined: no BTB storage; PredTarget and PredTargetValid SHALL be tied to 0.

Structure
REQ-031 Package bp_pkg SHALL hold the default parameter values, the counter reset constant function, and the BTB entry typedef.
REQ-032 The BTB SHALL be a sub-module named branch_target_buffer, instantiated only under BP_BTB_EN.

Verification
REQ-033 Reset, then lookup at PC 0x40 -> next cycle PredValid=1, Prediction=0, PredIndex_ID=0x10.
REQ-034 Two taken updates at index 0x10 with history 0, then lookup at PC 0x40 with the history forced back to 0 via not-taken updates at another index -> Prediction=1; six further taken updates -> counter holds at 3.
REQ-035 Taken, taken, not-taken, taken resolutions -> history=4'b1101; lookup at PC 0x0 -> PredIndex_ID=0x0D.
REQ-036 Same-cycle update (taken, counter at 1) and lookup on the same index -> Prediction=1 via bypass; PredIndex_ID uses the pre-shift history.
REQ-037 With BP_BTB_EN: taken resolution PC 0x100 -> target 0x200, then lookup at 0x100 -> PredTargetValid=1, PredTarget=0x200; lookup at 0x1100 -> PredTargetValid=0.
REQ-038 Assert Reset for one cycle mid-stream with a lookup and an update pending -> counters, history and BTB valid bits cleared; PredValid=0 in the next cycle.
